// File: rtl/grf_wb_ctrl.sv
// Write-back controller: owns the single GRF write port, arbitrating between pipeline
// retirement and out-of-band multiply/divide results, and tracks per-register MD busy bits.
module grf_wb_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_valid,
  input  logic              pipe_wen,
  input  logic [ADDR_W-1:0] pipe_rd,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              md_issue,
  input  logic [ADDR_W-1:0] md_issue_rd,
  output logic              md_issue_stall,
  input  logic              md_done_valid,
  input  logic [ADDR_W-1:0] md_done_rd,
  input  logic [DATA_W-1:0] md_done_data,
  output logic              md_done_ready,
  input  logic [ADDR_W-1:0] q_rs,
  input  logic [ADDR_W-1:0] q_rt,
  output logic              q_rs_busy,
  output logic              q_rt_busy,
  output logic              grf_we,
  output logic [ADDR_W-1:0] grf_waddr,
  output logic [DATA_W-1:0] grf_wd,
  output logic              err_waw
);

  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic              hold_valid;
  logic [ADDR_W-1:0] hold_rd;
  logic [DATA_W-1:0] hold_data;

  logic              pipe_req;
  logic              md_acc;
  logic              md_acc_live;
  logic              set_en;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_rd;

  assign pipe_req       = pipe_valid && pipe_wen && (pipe_rd != '0);
  assign md_done_ready  = !hold_valid && !reset;
  assign md_acc         = md_done_valid && md_done_ready;
  // Results for r0 are accepted but carry nothing worth writing or tracking.
  assign md_acc_live    = md_acc && (md_done_rd != '0);
  assign md_issue_stall = busy[md_issue_rd];
  assign q_rs_busy      = busy[q_rs];
  assign q_rt_busy      = busy[q_rt];

  assign set_en = md_issue && (md_issue_rd != '0) && !md_issue_stall;

  // A busy bit clears only when its MD result actually lands on the write port.
  always_comb begin
    clr_en = 1'b0;
    clr_rd = '0;
    if (!pipe_req) begin
      if (hold_valid) begin
        clr_en = 1'b1;
        clr_rd = hold_rd;
      end else if (md_acc_live) begin
        clr_en = 1'b1;
        clr_rd = md_done_rd;
      end
    end
  end

  // Set after clear so a same-cycle reissue to the same register stays busy.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_rd] = 1'b0;
    if (set_en) busy_nxt[md_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grf_we     <= 1'b0;
      grf_waddr  <= '0;
      grf_wd     <= '0;
      hold_valid <= 1'b0;
      hold_rd    <= '0;
      hold_data  <= '0;
    end else if (pipe_req) begin
      grf_we    <= 1'b1;
      grf_waddr <= pipe_rd;
      grf_wd    <= pipe_data;
      if (md_acc_live) begin
        hold_valid <= 1'b1;
        hold_rd    <= md_done_rd;
        hold_data  <= md_done_data;
      end
    end else if (hold_valid) begin
      grf_we     <= 1'b1;
      grf_waddr  <= hold_rd;
      grf_wd     <= hold_data;
      hold_valid <= 1'b0;
    end else if (md_acc_live) begin
      grf_we    <= 1'b1;
      grf_waddr <= md_done_rd;
      grf_wd    <= md_done_data;
    end else begin
      grf_we <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_waw <= 1'b0;
    end else if (pipe_req && busy[pipe_rd]) begin
      err_waw <= 1'b1;
    end
  end

endmodule

// File: tb/tb_grf_wb_ctrl.sv
// Directed bench for grf_wb_ctrl: each task drives one scenario and checks
// hand-computed write-port, scoreboard and handshake values.
module tb_grf_wb_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_valid, pipe_wen;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        md_issue;
  logic [4:0]  md_issue_rd;
  logic        md_issue_stall;
  logic        md_done_valid;
  logic [4:0]  md_done_rd;
  logic [31:0] md_done_data;
  logic        md_done_ready;
  logic [4:0]  q_rs, q_rt;
  logic        q_rs_busy, q_rt_busy;
  logic        grf_we;
  logic [4:0]  grf_waddr;
  logic [31:0] grf_wd;
  logic        err_waw;

  int checks = 0;
  int errors = 0;

  grf_wb_ctrl #(.ADDR_W(5), .DATA_W(32), .NREG(32)) dut (
    .clk(clk), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_wen(pipe_wen), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .md_issue(md_issue), .md_issue_rd(md_issue_rd), .md_issue_stall(md_issue_stall),
    .md_done_valid(md_done_valid), .md_done_rd(md_done_rd), .md_done_data(md_done_data),
    .md_done_ready(md_done_ready),
    .q_rs(q_rs), .q_rt(q_rt), .q_rs_busy(q_rs_busy), .q_rt_busy(q_rt_busy),
    .grf_we(grf_we), .grf_waddr(grf_waddr), .grf_wd(grf_wd), .err_waw(err_waw)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_valid = 0; pipe_wen = 0; pipe_rd = 0; pipe_data = 0;
    md_issue = 0; md_issue_rd = 0;
    md_done_valid = 0; md_done_rd = 0; md_done_data = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    q_rs = 0; q_rt = 0;
    reset = 1;
    step();
    checks++;
    if (md_done_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b want 0", md_done_ready);
    end
    step();
    reset = 0;
    #1;
    checks++;
    if ({grf_we, grf_waddr, grf_wd, err_waw} !== 39'd0) begin
      errors++; $display("FAIL reset_outputs: we=%b addr=%0d wd=%h err=%b want all 0",
                         grf_we, grf_waddr, grf_wd, err_waw);
    end
    checks++;
    if (md_done_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_after: got %b want 1", md_done_ready);
    end
  endtask

  task automatic test_pipe();
    pipe_valid = 1; pipe_wen = 1; pipe_rd = 5; pipe_data = 32'h1234;
    step();
    idle_inputs();
    checks++;
    if ({grf_we, grf_waddr, grf_wd} !== {1'b1, 5'd5, 32'h1234}) begin
      errors++; $display("FAIL pipe_write: we=%b addr=%0d wd=%h want 1/5/1234", grf_we, grf_waddr, grf_wd);
    end
    step();
    checks++;
    if ({grf_we, grf_waddr, grf_wd} !== {1'b0, 5'd5, 32'h1234}) begin
      errors++; $display("FAIL pipe_idle: we=%b addr=%0d wd=%h want 0/5/1234", grf_we, grf_waddr, grf_wd);
    end
    // retiring instruction without a register write
    pipe_valid = 1; pipe_wen = 0; pipe_rd = 6; pipe_data = 32'h66;
    step();
    idle_inputs();
    checks++;
    if (grf_we !== 1'b0) begin
      errors++; $display("FAIL pipe_nowen: we=%b want 0", grf_we);
    end
  endtask

  task automatic test_md();
    md_issue = 1; md_issue_rd = 8;
    step();
    idle_inputs();
    q_rs = 8; md_issue_rd = 8;
    #1;
    checks++;
    if (q_rs_busy !== 1'b1 || md_issue_stall !== 1'b1) begin
      errors++; $display("FAIL md_busy_set: busy=%b stall=%b want 1/1", q_rs_busy, md_issue_stall);
    end
    md_done_valid = 1; md_done_rd = 8; md_done_data = 32'hCAFE;
    step();
    idle_inputs();
    checks++;
    if ({grf_we, grf_waddr, grf_wd, q_rs_busy} !== {1'b1, 5'd8, 32'hCAFE, 1'b0}) begin
      errors++; $display("FAIL md_write: we=%b addr=%0d wd=%h busy=%b want 1/8/cafe/0",
                         grf_we, grf_waddr, grf_wd, q_rs_busy);
    end
  endtask

  task automatic test_conflict();
    md_issue = 1; md_issue_rd = 9;
    step();
    idle_inputs();
    q_rt = 9;
    pipe_valid = 1; pipe_wen = 1; pipe_rd = 3; pipe_data = 32'h33;
    md_done_valid = 1; md_done_rd = 9; md_done_data = 32'hBEEF;
    step();
    idle_inputs();
    checks++;
    if ({grf_we, grf_waddr, grf_wd, md_done_ready, q_rt_busy} !== {1'b1, 5'd3, 32'h33, 1'b0, 1'b1}) begin
      errors++; $display("FAIL conflict_pipe: we=%b addr=%0d wd=%h rdy=%b busy=%b want 1/3/33/0/1",
                         grf_we, grf_waddr, grf_wd, md_done_ready, q_rt_busy);
    end
    step();
    checks++;
    if ({grf_we, grf_waddr, grf_wd, md_done_ready, q_rt_busy} !== {1'b1, 5'd9, 32'hBEEF, 1'b1, 1'b0}) begin
      errors++; $display("FAIL conflict_held: we=%b addr=%0d wd=%h rdy=%b busy=%b want 1/9/beef/1/0",
                         grf_we, grf_waddr, grf_wd, md_done_ready, q_rt_busy);
    end
  endtask

  task automatic test_sustained();
    logic [4:0] exp_rd;
    md_issue = 1; md_issue_rd = 10;
    step();
    idle_inputs();
    q_rs = 10;
    for (int i = 0; i < 4; i++) begin
      pipe_valid = 1; pipe_wen = 1; pipe_rd = 5'(11 + i); pipe_data = 32'(32'h100 + i);
      md_done_valid = 1;
      md_done_rd   = (i == 0) ? 5'd10 : 5'd15;
      md_done_data = (i == 0) ? 32'hAAAA : 32'hBBBB;
      step();
      exp_rd = 5'(11 + i);
      checks++;
      if ({grf_we, grf_waddr, grf_wd, md_done_ready, q_rs_busy} !== {1'b1, exp_rd, 32'(32'h100 + i), 1'b0, 1'b1}) begin
        errors++; $display("FAIL sustained_pipe%0d: we=%b addr=%0d wd=%h rdy=%b busy=%b want 1/%0d/%h/0/1",
                           i, grf_we, grf_waddr, grf_wd, md_done_ready, q_rs_busy, exp_rd, 32'(32'h100 + i));
      end
    end
    pipe_valid = 0; pipe_wen = 0; pipe_rd = 0; pipe_data = 0;
    step();
    checks++;
    if ({grf_we, grf_waddr, grf_wd, md_done_ready, q_rs_busy} !== {1'b1, 5'd10, 32'hAAAA, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sustained_held: we=%b addr=%0d wd=%h rdy=%b busy=%b want 1/10/aaaa/1/0",
                         grf_we, grf_waddr, grf_wd, md_done_ready, q_rs_busy);
    end
    step();
    idle_inputs();
    checks++;
    if ({grf_we, grf_waddr, grf_wd} !== {1'b1, 5'd15, 32'hBBBB}) begin
      errors++; $display("FAIL sustained_second: we=%b addr=%0d wd=%h want 1/15/bbbb", grf_we, grf_waddr, grf_wd);
    end
    step();
    checks++;
    if (grf_we !== 1'b0) begin
      errors++; $display("FAIL sustained_idle: we=%b want 0", grf_we);
    end
  endtask

  task automatic test_zero();
    pipe_valid = 1; pipe_wen = 1; pipe_rd = 0; pipe_data = 32'h77;
    step();
    idle_inputs();
    checks++;
    if (grf_we !== 1'b0) begin
      errors++; $display("FAIL zero_pipe: we=%b want 0", grf_we);
    end
    md_issue = 1; md_issue_rd = 0;
    #1;
    checks++;
    if (md_issue_stall !== 1'b0) begin
      errors++; $display("FAIL zero_stall: got %b want 0", md_issue_stall);
    end
    step();
    idle_inputs();
    q_rs = 0;
    #1;
    checks++;
    if (q_rs_busy !== 1'b0) begin
      errors++; $display("FAIL zero_busy: got %b want 0", q_rs_busy);
    end
    md_done_valid = 1; md_done_rd = 0; md_done_data = 32'h99;
    #1;
    checks++;
    if (md_done_ready !== 1'b1) begin
      errors++; $display("FAIL zero_ready_pre: got %b want 1", md_done_ready);
    end
    step();
    idle_inputs();
    checks++;
    if (grf_we !== 1'b0 || md_done_ready !== 1'b1) begin
      errors++; $display("FAIL zero_done: we=%b rdy=%b want 0/1", grf_we, md_done_ready);
    end
  endtask

  task automatic test_set_wins();
    q_rs = 7;
    md_issue = 1; md_issue_rd = 7;
    md_done_valid = 1; md_done_rd = 7; md_done_data = 32'h7777;
    step();
    idle_inputs();
    checks++;
    if ({grf_we, grf_waddr, grf_wd, q_rs_busy} !== {1'b1, 5'd7, 32'h7777, 1'b1}) begin
      errors++; $display("FAIL set_wins: we=%b addr=%0d wd=%h busy=%b want 1/7/7777/1",
                         grf_we, grf_waddr, grf_wd, q_rs_busy);
    end
    md_done_valid = 1; md_done_rd = 7; md_done_data = 32'h7778;
    step();
    idle_inputs();
    checks++;
    if (q_rs_busy !== 1'b0) begin
      errors++; $display("FAIL set_wins_clear: busy=%b want 0", q_rs_busy);
    end
  endtask

  task automatic test_waw_reset();
    md_issue = 1; md_issue_rd = 4;
    step();
    idle_inputs();
    checks++;
    if (err_waw !== 1'b0) begin
      errors++; $display("FAIL waw_pre: err=%b want 0", err_waw);
    end
    pipe_valid = 1; pipe_wen = 1; pipe_rd = 4; pipe_data = 32'h44;
    step();
    idle_inputs();
    checks++;
    if ({err_waw, grf_we, grf_waddr, grf_wd} !== {1'b1, 1'b1, 5'd4, 32'h44}) begin
      errors++; $display("FAIL waw_write: err=%b we=%b addr=%0d wd=%h want 1/1/4/44",
                         err_waw, grf_we, grf_waddr, grf_wd);
    end
    md_issue = 1; md_issue_rd = 4;
    #1;
    checks++;
    if (md_issue_stall !== 1'b1) begin
      errors++; $display("FAIL waw_stall: got %b want 1", md_issue_stall);
    end
    step();
    idle_inputs();
    md_issue = 1; md_issue_rd = 20;
    step();
    idle_inputs();
    pipe_valid = 1; pipe_wen = 1; pipe_rd = 21; pipe_data = 32'h21;
    md_done_valid = 1; md_done_rd = 20; md_done_data = 32'h2020;
    step();
    idle_inputs();
    checks++;
    if (md_done_ready !== 1'b0) begin
      errors++; $display("FAIL reset_mid_held: rdy=%b want 0", md_done_ready);
    end
    reset = 1;
    step();
    q_rs = 4; q_rt = 20;
    #1;
    checks++;
    if ({grf_we, grf_waddr, grf_wd, err_waw, q_rs_busy, q_rt_busy, md_done_ready} !== 42'd0) begin
      errors++; $display("FAIL reset_mid: we=%b addr=%0d wd=%h err=%b b4=%b b20=%b rdy=%b want all 0",
                         grf_we, grf_waddr, grf_wd, err_waw, q_rs_busy, q_rt_busy, md_done_ready);
    end
    reset = 0;
    step();
    checks++;
    if (grf_we !== 1'b0 || md_done_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_drop: we=%b rdy=%b want 0/1", grf_we, md_done_ready);
    end
  endtask

  initial begin
    test_reset();
    test_pipe();
    test_md();
    test_conflict();
    test_sustained();
    test_zero();
    test_set_wins();
    test_waw_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
